// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    // Occupancy of the single writeback slot.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    // Load width/sign encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction and legality/alignment check.
// Picks the addressed byte or halfword out of a word-aligned read
// and extends it; flags unknown widths and misaligned halfword/word loads.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte by addr[1:0], halfword by addr[1].
    assign w_byte = mem_rdata[{addr, 3'b000} +: 8];
    assign w_half = mem_rdata[{addr[1], 4'b0000} +: 16];

    // Extend the selected lane and decide whether the access is legal.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (which would infer a latch).
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                data  = {{(XLEN-16){w_half[15]}}, w_half};
                fault = addr[0];
            end
            F3_LHU: begin
                data  = {{(XLEN-16){1'b0}}, w_half};
                fault = addr[0];
            end
            F3_LW: begin
                data  = mem_rdata;
                fault = |addr;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data
// when needed, and drives the register file write port for one cycle.
// Faulted loads commit without writing and pulse misaligned instead.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              write,
    output logic [REG_AW-1:0] w_reg,
    output logic [XLEN-1:0]   w_dat,
    output logic              misaligned,
    output logic [CNT_W-1:0]  retired
);

    wb_state_t         r_state;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_funct3;
    logic              r_fault;
    logic [REG_AW-1:0] r_last_reg;
    logic [XLEN-1:0]   r_last_dat;
    logic [CNT_W-1:0]  r_retired;

    logic              w_commit;
    logic              w_accept;
    logic              w_in_wait;
    logic [1:0]        w_align_addr;
    logic [2:0]        w_align_f3;
    logic [XLEN-1:0]   w_align_data;
    logic              w_align_fault;
    logic              w_go_wait;
    logic              w_to_commit;

    assign w_commit  = (r_state == COMMIT);
    assign w_in_wait = (r_state == WAIT_MEM);
    assign in_ready  = (r_state == EMPTY) || w_commit;
    assign w_accept  = in_valid && in_ready;

    // The aligner checks the incoming instruction while the slot can accept,
    // and extracts from the held address while a load is waiting for data.
    assign w_align_addr = w_in_wait ? r_result[1:0] : in_result[1:0];
    assign w_align_f3   = w_in_wait ? r_funct3      : in_funct3;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .mem_rdata (mem_rdata),
        .addr      (w_align_addr),
        .funct3    (w_align_f3),
        .data      (w_align_data),
        .fault     (w_align_fault)
    );

    // Only a legal, aligned load waits for memory; everything else commits next.
    assign w_go_wait   = in_is_load && !w_align_fault;
    assign w_to_commit = (w_accept && !w_go_wait) || (w_in_wait && mem_rvalid);

    // Slot state machine, held instruction, last-committed values and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_rd       <= '0;
            r_result   <= '0;
            r_funct3   <= '0;
            r_fault    <= 1'b0;
            r_last_reg <= '0;
            r_last_dat <= '0;
            r_retired  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
            case (r_state)
                EMPTY, COMMIT: begin
                    if (w_accept) begin
                        r_rd     <= in_rd;
                        r_result <= in_result;
                        r_funct3 <= in_funct3;
                        r_fault  <= in_is_load && w_align_fault;
                        r_state  <= w_go_wait ? WAIT_MEM : COMMIT;
                    end else begin
                        r_state  <= EMPTY;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_result <= w_align_data;
                        r_state  <= COMMIT;
                    end
                end
                default: r_state <= EMPTY;
            endcase

            if (w_commit) begin
                r_last_reg <= r_rd;
                r_last_dat <= r_result;
            end

            // Counted on entry to COMMIT so the count includes the instruction being committed.
            if (w_to_commit) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign write      = w_commit && !r_fault && (r_rd != '0);
    assign misaligned = w_commit && r_fault;
    assign w_reg      = w_commit ? r_rd     : r_last_reg;
    assign w_dat      = w_commit ? r_result : r_last_dat;
    assign retired    = r_retired;

endmodule
